ser_frame_sched: RTL and testbench

SER_FRAME_SCHED -- requirements
Module: ser_frame_sched

---
 rtl/ser_frame_sched.sv | 211 +++++++++++++++++++++
 tb/tb_ser_frame_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_sched.sv
// ser_frame_sched
//   Character-slot scheduler feeding an 8b10b encoder. A free-running slot
//   counter divides fclk by ten. Each slot boundary (wren) may present a new
//   character. Frames are built from 24-bit records pulled from two
//   requesters. Each frame has the form: SOF, then three bytes per record,
//   then EOF. Between frames the scheduler emits a minimum number of IDLE
//   characters.
//
//   The current character is combinational in the wren cycle. Because of
//   this, a granted record's top byte appears on char_out in the same cycle
//   as its ack. For the rest of the slot, the character comes from
//   registered state.
//
//   Arbitration: if both requesters are asking, the one that was not
//   granted last wins. The pointer is initialised so that service wins
//   first after reset.
//
// Parameters
//   MAX_REC  : records per frame before a forced EOF (only with FRAME_LIMIT_EN)
//   IDLE_GAP : minimum IDLE characters between EOF and the next SOF (1..15)
//
// Optional feature macro: FRAME_LIMIT_EN. When it is defined, a frame is
// closed after MAX_REC records. When it is undefined, frames are unbounded,
// and neither MAX_REC nor the record counter exists.
//
// Ports
//   fclk              character-slot clock, rising edge
//   reset             synchronous, active-high
//   enable            permits new frames and new grants
//   sv_req / sv_data  service record requester, 24-bit record
//   sv_ack            one-cycle pulse when sv_data is taken
//   dh_req / dh_data  hit-data record requester, 24-bit record
//   dh_ack            one-cycle pulse when dh_data is taken
//   char_out / k_out  character and K flag to the encoder
//   wren              serializer load strobe, one cycle in ten
//   busy              high while a frame character (SOF..EOF) is on char_out
module ser_frame_sched #(
`ifdef FRAME_LIMIT_EN
  parameter int MAX_REC  = 16,
`endif
  parameter int IDLE_GAP = 1
) (
  input  logic        fclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sv_req,
  input  logic [23:0] sv_data,
  output logic        sv_ack,
  input  logic        dh_req,
  input  logic [23:0] dh_data,
  output logic        dh_ack,
  output logic [7:0]  char_out,
  output logic        k_out,
  output logic        wren,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF  = 3'd1,
    S_B0   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4,
    S_EOF  = 3'd5
  } state_t;

  localparam logic [7:0] K_IDLE  = 8'h3C;  // K28.1
  localparam logic [7:0] K_SOF   = 8'hFC;  // K28.7
  localparam logic [7:0] K_EOF   = 8'hBC;  // K28.5
  localparam logic [3:0] GAP_MIN = 4'(IDLE_GAP);
  localparam logic [3:0] GAP_SAT = 4'hF;

  logic [3:0]  r_slot;
  state_t      r_state;
  logic [23:0] r_hold;
  logic [3:0]  r_gap;        // IDLE characters issued since the last EOF
  logic        r_prefer_dh;  // set after a service grant

  logic        w_wren;
  logic        w_can_grant;
  logic        w_any_req;
  logic        w_grant_sv;
  logic        w_grant_dh;
  logic [23:0] w_sel_data;
  state_t      w_next_state;
  state_t      w_shown;

`ifdef FRAME_LIMIT_EN
  localparam int               REC_W   = $clog2(MAX_REC + 1);
  localparam logic [REC_W-1:0] REC_MAX = REC_W'(MAX_REC);
  logic [REC_W-1:0] r_rec_cnt;
`endif

  // Reset holds the slot counter at 0 and suppresses the strobe. This makes
  // the first cycle after reset a slot boundary.
  assign w_wren    = (r_slot == 4'd0) && !reset;
  assign w_any_req = sv_req | dh_req;

  always_comb begin
    w_can_grant = enable;
`ifdef FRAME_LIMIT_EN
    if (r_rec_cnt >= REC_MAX) w_can_grant = 1'b0;
`endif
  end

  // Next-state and grant decision. It only takes effect in the wren cycle.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch.
    // Otherwise a path that does not assign it would infer a latch.
    w_next_state = r_state;
    w_grant_sv   = 1'b0;
    w_grant_dh   = 1'b0;
    if (w_wren) begin
      case (r_state)
        S_IDLE: begin
          if (enable && w_any_req && (r_gap >= GAP_MIN)) w_next_state = S_SOF;
        end
        S_SOF, S_B2: begin
          if (w_can_grant && w_any_req) begin
            w_next_state = S_B0;
            if (sv_req && (!dh_req || !r_prefer_dh)) w_grant_sv = 1'b1;
            else                                     w_grant_dh = 1'b1;
          end else begin
            w_next_state = S_EOF;
          end
        end
        S_B0:    w_next_state = S_B1;
        S_B1:    w_next_state = S_B2;
        S_EOF:   w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  assign w_sel_data = w_grant_dh ? dh_data : sv_data;

  // Character selection. In the wren cycle the incoming state is shown, so a
  // newly granted record's top byte is taken straight from the winner's bus.
  always_comb begin
    w_shown  = w_wren ? w_next_state : r_state;
    char_out = K_IDLE;
    k_out    = 1'b1;
    case (w_shown)
      S_SOF: char_out = K_SOF;
      S_B0: begin
        char_out = w_wren ? w_sel_data[23:16] : r_hold[23:16];
        k_out    = 1'b0;
      end
      S_B1: begin
        char_out = r_hold[15:8];
        k_out    = 1'b0;
      end
      S_B2: begin
        char_out = r_hold[7:0];
        k_out    = 1'b0;
      end
      S_EOF:   char_out = K_EOF;
      default: char_out = K_IDLE;
    endcase
    // Reset forces the line to IDLE immediately, including in the cycle in
    // which reset is first sampled.
    if (reset) begin
      char_out = K_IDLE;
      k_out    = 1'b1;
    end
  end

  assign wren   = w_wren;
  assign busy   = !reset && (w_shown != S_IDLE);
  assign sv_ack = w_grant_sv;
  assign dh_ack = w_grant_dh;

  always_ff @(posedge fclk) begin
    // NOTE: all state is assigned non-blocking. Every register then samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      r_slot      <= 4'd0;
      r_state     <= S_IDLE;
      r_hold      <= 24'd0;
      r_gap       <= GAP_SAT;
      r_prefer_dh <= 1'b0;
    end else begin
      r_slot <= (r_slot == 4'd9) ? 4'd0 : r_slot + 4'd1;
      if (w_wren) begin
        r_state <= w_next_state;
        if (w_next_state == S_EOF) begin
          r_gap <= 4'd0;
        end else if ((w_next_state == S_IDLE) && (r_gap != GAP_SAT)) begin
          r_gap <= r_gap + 4'd1;
        end
      end
      if (w_grant_sv || w_grant_dh) begin
        r_hold      <= w_sel_data;
        r_prefer_dh <= w_grant_sv;
      end
    end
  end

`ifdef FRAME_LIMIT_EN
  always_ff @(posedge fclk) begin
    if (reset) begin
      r_rec_cnt <= '0;
    end else if (w_wren && (w_next_state == S_SOF)) begin
      r_rec_cnt <= '0;
    end else if (w_grant_sv || w_grant_dh) begin
      r_rec_cnt <= r_rec_cnt + REC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ser_frame_sched.sv
// tb_ser_frame_sched
//   Self-checking bench for ser_frame_sched. A character-level model tracks
//   the line: a queue of pending record bytes, a frame-open flag, an idle
//   counter and the last winner. It predicts wren, char_out, k_out, busy and
//   both acks on every cycle. Directed scenarios add literal expectations on
//   the logged character stream, and a randomized phase follows them.
//   Build with +define+FRAME_LIMIT_EN to exercise the record limit
//   (MAX_REC=2).
module tb_ser_frame_sched;

  localparam int GAP = 3;
`ifdef FRAME_LIMIT_EN
  localparam int LIMIT = 2;
`else
  localparam int LIMIT = 1 << 30;
`endif

  logic        fclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sv_req = 1'b0;
  logic [23:0] sv_data = 24'd0;
  logic        sv_ack;
  logic        dh_req = 1'b0;
  logic [23:0] dh_data = 24'd0;
  logic        dh_ack;
  logic [7:0]  char_out;
  logic        k_out;
  logic        wren;
  logic        busy;

  ser_frame_sched #(
`ifdef FRAME_LIMIT_EN
    .MAX_REC (2),
`endif
    .IDLE_GAP(GAP)
  ) dut (
    .fclk    (fclk),
    .reset   (reset),
    .enable  (enable),
    .sv_req  (sv_req),
    .sv_data (sv_data),
    .sv_ack  (sv_ack),
    .dh_req  (dh_req),
    .dh_data (dh_data),
    .dh_ack  (dh_ack),
    .char_out(char_out),
    .k_out   (k_out),
    .wren    (wren),
    .busy    (busy)
  );

  always #5 fclk = ~fclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Observation logs: one entry per wren seen on the DUT.
  logic [8:0] chr_log[$];   // {k_out, char_out}
  logic [1:0] ack_log[$];   // {sv_ack, dh_ack}
  int         wcyc_log[$];  // cycle index since reset release
  int         cyc;

  // Behavioural model state.
  int         m_slot;
  bit         m_open;
  logic [8:0] m_pend[$];
  int         m_idle;
  int         m_recs;
  bit         m_last_dh;
  logic [8:0] m_shown;

  always @(negedge fclk) begin
    logic       e_wren, e_sv, e_dh, e_busy;
    logic [23:0] d;
    bit         pick_dh;
    e_wren = 1'b0; e_sv = 1'b0; e_dh = 1'b0; e_busy = 1'b0;
    if (reset) begin
      m_slot = 0; m_open = 1'b0; m_pend.delete(); m_idle = 1000;
      m_recs = 0; m_last_dh = 1'b1; m_shown = 9'h13C; cyc = 0;
    end else begin
      e_wren = (m_slot == 0);
      if (e_wren) begin
        if (m_pend.size() > 0) begin
          m_shown = m_pend.pop_front();
        end else if (m_open) begin
          if (enable && (sv_req || dh_req) && (m_recs < LIMIT)) begin
            pick_dh = dh_req && (!sv_req || !m_last_dh);
            d = pick_dh ? dh_data : sv_data;
            m_shown = {1'b0, d[23:16]};
            m_pend.push_back({1'b0, d[15:8]});
            m_pend.push_back({1'b0, d[7:0]});
            m_recs++;
            m_last_dh = pick_dh;
            e_dh = pick_dh;
            e_sv = !pick_dh;
          end else begin
            m_shown = 9'h1BC;
            m_open  = 1'b0;
            m_idle  = 0;
          end
        end else if (enable && (sv_req || dh_req) && (m_idle >= GAP)) begin
          m_shown = 9'h1FC;
          m_open  = 1'b1;
          m_recs  = 0;
        end else begin
          m_shown = 9'h13C;
          m_idle++;
        end
      end
      m_slot = (m_slot + 1) % 10;
      e_busy = (m_shown != 9'h13C);
    end
    check("wren",     wren,     e_wren);
    check("char_out", char_out, m_shown[7:0]);
    check("k_out",    k_out,    m_shown[8]);
    check("busy",     busy,     e_busy);
    check("sv_ack",   sv_ack,   e_sv);
    check("dh_ack",   dh_ack,   e_dh);
    if (!reset) begin
      if (wren) begin
        chr_log.push_back({k_out, char_out});
        ack_log.push_back({sv_ack, dh_ack});
        wcyc_log.push_back(cyc);
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic clear_log();
    chr_log.delete(); ack_log.delete(); wcyc_log.delete();
  endtask

  task automatic wait_ack(input bit want_dh, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge fclk);
      if (want_dh ? dh_ack : sv_ack) got = 1'b1;
    end
    check({tag, " ack seen"}, got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g[$];
    int n;
    logic [8:0] exp_lim[12];
    exp_lim = '{9'h1FC, 9'h00C, 9'h00D, 9'h00E, 9'h00C, 9'h00D,
                9'h00E, 9'h1BC, 9'h13C, 9'h13C, 9'h13C, 9'h1FC};

    // Reset release with no requests: IDLE stream, wren every ten cycles.
    step(3);
    clear_log();
    reset = 1'b0;
    step(35);
    for (int i = 0; i < 4; i++) check("idle wren cycle", wcyc_log[i], i * 10);
    check("idle char", chr_log[0], 9'h13C);
    check("idle busy", busy, 0);

    // Single service record.
    clear_log();
    enable  = 1'b1;
    sv_data = 24'hA1B2C3;
    sv_req  = 1'b1;
    wait_ack(1'b0, "single");
    step(1);
    sv_req = 1'b0;
    step(70);
    check("single sof",  chr_log[0], 9'h1FC);
    check("single b0",   chr_log[1], 9'h0A1);
    check("single b1",   chr_log[2], 9'h0B2);
    check("single b2",   chr_log[3], 9'h0C3);
    check("single eof",  chr_log[4], 9'h1BC);
    check("single idle", chr_log[5], 9'h13C);
    check("single ack slot", ack_log[1], 2'b10);

    // Both requesters held: grants alternate, service first after reset.
    reset = 1'b1;
    step(2);
    sv_data = 24'h111111; dh_data = 24'h222222;
    sv_req = 1'b1; dh_req = 1'b1; enable = 1'b1;
    clear_log();
    reset = 1'b0;
    step(140);
    sv_req = 1'b0; dh_req = 1'b0;
    step(60);
    foreach (ack_log[i]) if (ack_log[i] != 2'b00) g.push_back(int'(ack_log[i]));
    check("alt grant count ok", g.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("alt grant order", g[i], (i % 2 == 0) ? 2 : 1);
    check("alt first byte",  chr_log[1], 9'h011);
    check("alt second byte", chr_log[4], 9'h022);
`ifdef FRAME_LIMIT_EN
    check("alt limit eof", chr_log[7], 9'h1BC);
`else
    check("alt third rec", chr_log[7], 9'h011);
`endif

    // Enable dropped during B1: B2 completes, then EOF, no more grants.
    reset = 1'b1;
    step(2);
    sv_data = 24'h5A6B7C; sv_req = 1'b1; dh_req = 1'b1; dh_data = 24'h333333;
    enable = 1'b1;
    clear_log();
    reset = 1'b0;
    wait_ack(1'b0, "drop");
    step(13);
    enable = 1'b0;
    step(60);
    check("drop sof",  chr_log[0], 9'h1FC);
    check("drop b0",   chr_log[1], 9'h05A);
    check("drop b1",   chr_log[2], 9'h06B);
    check("drop b2",   chr_log[3], 9'h07C);
    check("drop eof",  chr_log[4], 9'h1BC);
    check("drop idle", chr_log[5], 9'h13C);
    n = 0;
    foreach (ack_log[i]) if (ack_log[i] != 2'b00) n++;
    check("drop ack count", n, 1);
    sv_req = 1'b0; dh_req = 1'b0;

    // Hit-data requester held continuously.
    reset = 1'b1;
    step(2);
    dh_data = 24'h0C0D0E; dh_req = 1'b1; enable = 1'b1;
    clear_log();
    reset = 1'b0;
    step(130);
`ifdef FRAME_LIMIT_EN
    for (int i = 0; i < 12; i++) check("limit stream", chr_log[i], exp_lim[i]);
`else
    check("stream sof",     chr_log[0], 9'h1FC);
    check("stream no eof",  chr_log[7], 9'h00C);
`endif
    dh_req = 1'b0;

    // Reset during B0: frame abandoned with no EOF.
    reset = 1'b1;
    step(2);
    sv_data = 24'h9A8B7C; sv_req = 1'b1; enable = 1'b1;
    reset = 1'b0;
    wait_ack(1'b0, "rst");
    step(3);
    sv_req = 1'b0; enable = 1'b0; reset = 1'b1;
    @(negedge fclk);
    check("rst char", char_out, 8'h3C);
    check("rst k",    k_out, 1);
    check("rst busy", busy, 0);
    step(1);
    @(negedge fclk);
    check("rst char after edge", char_out, 8'h3C);
    check("rst busy after edge", busy, 0);
    step(1);
    clear_log();
    reset = 1'b0;
    step(40);
    n = 0;
    foreach (chr_log[i]) if (chr_log[i] == 9'h1BC) n++;
    check("rst no eof", n, 0);
    check("rst first char", chr_log[0], 9'h13C);

    // Randomized traffic against the model.
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      reset = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 15) == 0) sv_req = ~sv_req;
      if ($urandom_range(0, 15) == 0) dh_req = ~dh_req;
      if ($urandom_range(0, 7) == 0) sv_data = 24'($urandom);
      if ($urandom_range(0, 7) == 0) dh_data = 24'($urandom);
      if (enable) enable = ($urandom_range(0, 79) != 0);
      else        enable = ($urandom_range(0, 9) == 0);
    end
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
